uart_rx_fsm: RTL and testbench

Frame sequencer for the UART receiver. Watches the serial line, drives the shared edge/bit counter enable, and issues per-bit strobes to the data sampler, deserializer and start/parity/stop checkers. Qualifies each received byte with a single-cycle `data_valid`, or an error pulse. Sits in the UART_RX top between the line input and the counter/sampler/checker datapath.

---
 rtl/uart_rx_fsm_if.sv | 36 +++
 rtl/uart_rx_fsm.sv | 124 ++++++++++++
 tb/tb_uart_rx_fsm.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART RX frame sequencer and its counter/sampler/checker datapath.
// master = sequencer side, slave = datapath/line side.
interface uart_rx_fsm_if;

  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic [3:0] bit_cnt;
  logic [4:0] edge_cnt;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;

  logic       cnt_enable;
  logic       dat_samp_en;
  logic       deser_en;
  logic       strt_chk_en;
  logic       par_chk_en;
  logic       stp_chk_en;
  logic       data_valid;
  logic       frame_err;
  logic       parity_err;

  modport master (
    input  RX_IN, PAR_EN, Prescale, bit_cnt, edge_cnt, strt_glitch, par_err, stp_err,
    output cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
           data_valid, frame_err, parity_err
  );

  modport slave (
    output RX_IN, PAR_EN, Prescale, bit_cnt, edge_cnt, strt_glitch, par_err, stp_err,
    input  cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en,
           data_valid, frame_err, parity_err
  );

endinterface

// File: rtl/uart_rx_fsm.sv
// UART receiver frame sequencer: walks IDLE/START/DATA/PARITY/STOP/DONE, enables the
// bit datapath and qualifies each frame with one data_valid or error pulse.
module uart_rx_fsm #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic          CLK,
  input  logic          RST,
  uart_rx_fsm_if.master bus
);

  localparam int unsigned PW = 6;
  localparam int unsigned BW = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_e;

  state_e state_q, state_d;
  logic   par_en_q, par_en_d;
  logic   par_err_q, par_err_d;
  logic   stp_err_q, stp_err_d;

  logic   cnt_enable_q, dat_samp_en_q, strt_chk_en_q, par_chk_en_q, stp_chk_en_q;
  logic   data_valid_q, frame_err_q, parity_err_q;

  logic   last_edge;
  logic   last_bit;

  assign last_edge = ({1'b0, bus.edge_cnt} == (bus.Prescale - PW'(1)));
  assign last_bit  = (bus.bit_cnt == BW'(DATA_BITS));

  // Next-state and per-frame flag capture
  always_comb begin
    state_d   = state_q;
    par_en_d  = par_en_q;
    par_err_d = par_err_q;
    stp_err_d = stp_err_q;
    case (state_q)
      IDLE: begin
        if (!bus.RX_IN) begin
          state_d  = START;
          par_en_d = bus.PAR_EN;
        end
      end
      START: begin
        if (last_edge) state_d = bus.strt_glitch ? IDLE : DATA;
      end
      DATA: begin
        if (last_edge && last_bit) state_d = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (last_edge) begin
          par_err_d = bus.par_err;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (last_edge) begin
          stp_err_d = bus.stp_err;
          state_d   = DONE;
        end
      end
      DONE: begin
        par_err_d = 1'b0;
        stp_err_d = 1'b0;
        if (!bus.RX_IN) begin
          state_d  = START;
          par_en_d = bus.PAR_EN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, flags and outputs registered together; outputs decode the state being entered
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= IDLE;
      par_en_q      <= 1'b0;
      par_err_q     <= 1'b0;
      stp_err_q     <= 1'b0;
      cnt_enable_q  <= 1'b0;
      dat_samp_en_q <= 1'b0;
      strt_chk_en_q <= 1'b0;
      par_chk_en_q  <= 1'b0;
      stp_chk_en_q  <= 1'b0;
      data_valid_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      parity_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      par_en_q      <= par_en_d;
      par_err_q     <= par_err_d;
      stp_err_q     <= stp_err_d;
      cnt_enable_q  <= (state_d inside {START, DATA, PARITY, STOP});
      dat_samp_en_q <= (state_d inside {START, DATA, PARITY, STOP});
      strt_chk_en_q <= (state_d == START);
      par_chk_en_q  <= (state_d == PARITY);
      stp_chk_en_q  <= (state_d == STOP);
      data_valid_q  <= (state_d == DONE) && !par_err_d && !stp_err_d;
      frame_err_q   <= (state_d == DONE) && stp_err_d;
      parity_err_q  <= (state_d == DONE) && par_err_d;
    end
  end

  assign bus.cnt_enable  = cnt_enable_q;
  assign bus.dat_samp_en = dat_samp_en_q;
  assign bus.strt_chk_en = strt_chk_en_q;
  assign bus.par_chk_en  = par_chk_en_q;
  assign bus.stp_chk_en  = stp_chk_en_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.parity_err  = parity_err_q;
  // One shift per data bit, at the final oversample of that bit
  assign bus.deser_en    = (state_q == DATA) && last_edge;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm with a behavioural edge/bit counter; cycle k of a frame
// is the cycle following edge T0+k-1, sampled on the falling edge.
module tb_uart_rx_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_rx_fsm_if bus ();

  uart_rx_fsm #(.DATA_BITS(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Edge/bit counter: clears while cnt_enable is low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.edge_cnt <= 5'd0;
      bus.bit_cnt  <= 4'd0;
    end else if (!bus.cnt_enable) begin
      bus.edge_cnt <= 5'd0;
      bus.bit_cnt  <= 4'd0;
    end else if ({1'b0, bus.edge_cnt} == bus.Prescale - 6'd1) begin
      bus.edge_cnt <= 5'd0;
      bus.bit_cnt  <= bus.bit_cnt + 4'd1;
    end else begin
      bus.edge_cnt <= bus.edge_cnt + 5'd1;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  int deser_q[$];
  int dv_q[$];
  int fe_q[$];
  int pe_q[$];
  int strt_chk_n, par_chk_n, stp_chk_n, cnt0_n, cnt0_first;

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int all_outs();
    return int'({bus.cnt_enable, bus.dat_samp_en, bus.deser_en, bus.strt_chk_en,
                 bus.par_chk_en, bus.stp_chk_en, bus.data_valid, bus.frame_err,
                 bus.parity_err});
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Start a frame (RX_IN low before edge T0) and record outputs for cycles 1..kmax
  task automatic run_frame(input int p, input logic pe0, input logic pe1,
                           input int rx_low2, input int kmax);
    deser_q.delete(); dv_q.delete(); fe_q.delete(); pe_q.delete();
    strt_chk_n = 0; par_chk_n = 0; stp_chk_n = 0; cnt0_n = 0; cnt0_first = 0;
    bus.Prescale = 6'(p);
    bus.PAR_EN   = pe0;
    bus.RX_IN    = 1'b0;
    for (int k = 1; k <= kmax; k++) begin
      @(posedge clk);
      #1;
      bus.RX_IN  = (k == rx_low2) ? 1'b0 : 1'b1;
      bus.PAR_EN = (k >= 100) ? pe1 : pe0;
      @(negedge clk);
      if (bus.deser_en)    deser_q.push_back(k);
      if (bus.data_valid)  dv_q.push_back(k);
      if (bus.frame_err)   fe_q.push_back(k);
      if (bus.parity_err)  pe_q.push_back(k);
      if (bus.strt_chk_en) strt_chk_n++;
      if (bus.par_chk_en)  par_chk_n++;
      if (bus.stp_chk_en)  stp_chk_n++;
      if (!bus.cnt_enable) begin
        cnt0_n++;
        if (cnt0_first == 0) cnt0_first = k;
      end
    end
  endtask

  initial begin
    int dv_seen;
    int en_seen;
    bus.RX_IN       = 1'b1;
    bus.PAR_EN      = 1'b0;
    bus.Prescale    = 6'd8;
    bus.strt_glitch = 1'b0;
    bus.par_err     = 1'b0;
    bus.stp_err     = 1'b0;

    // Reset behaviour
    repeat (2) @(negedge clk);
    chk("reset_outs", all_outs(), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_reset_outs", all_outs(), 0);

    // Clean frame, P=8, no parity
    run_frame(8, 1'b0, 1'b0, 0, 84);
    chk("clean_deser_n", deser_q.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("clean_deser_at%0d", i), q_at(deser_q, i), 16 + 8 * i);
    chk("clean_dv_n", dv_q.size(), 1);
    chk("clean_dv_at", q_at(dv_q, 0), 81);
    chk("clean_fe_n", fe_q.size(), 0);
    chk("clean_pe_n", pe_q.size(), 0);
    chk("clean_strt_chk_n", strt_chk_n, 8);
    chk("clean_par_chk_n", par_chk_n, 0);
    chk("clean_stp_chk_n", stp_chk_n, 8);
    chk("clean_cnt0_first", cnt0_first, 81);
    chk("clean_cnt0_n", cnt0_n, 4);

    // Parity error, P=16
    bus.par_err = 1'b1;
    run_frame(16, 1'b1, 1'b1, 0, 180);
    bus.par_err = 1'b0;
    chk("perr_pe_n", pe_q.size(), 1);
    chk("perr_pe_at", q_at(pe_q, 0), 177);
    chk("perr_dv_n", dv_q.size(), 0);
    chk("perr_fe_n", fe_q.size(), 0);
    chk("perr_par_chk_n", par_chk_n, 16);
    chk("perr_deser_n", deser_q.size(), 8);
    chk("perr_cnt0_first", cnt0_first, 177);

    // Start glitch, P=8
    bus.strt_glitch = 1'b1;
    run_frame(8, 1'b0, 1'b0, 0, 20);
    bus.strt_glitch = 1'b0;
    chk("glitch_cnt0_first", cnt0_first, 9);
    chk("glitch_cnt0_n", cnt0_n, 12);
    chk("glitch_strt_chk_n", strt_chk_n, 8);
    chk("glitch_deser_n", deser_q.size(), 0);
    chk("glitch_pulses", dv_q.size() + fe_q.size() + pe_q.size(), 0);

    // Stop error, P=8
    bus.stp_err = 1'b1;
    run_frame(8, 1'b0, 1'b0, 0, 84);
    bus.stp_err = 1'b0;
    chk("serr_fe_n", fe_q.size(), 1);
    chk("serr_fe_at", q_at(fe_q, 0), 81);
    chk("serr_dv_n", dv_q.size(), 0);
    chk("serr_pe_n", pe_q.size(), 0);
    chk("serr_cnt0_n", cnt0_n, 4);

    // Back-to-back, P=32: PAR_EN rises mid frame 1, RX_IN low in DONE
    run_frame(32, 1'b0, 1'b1, 321, 676);
    chk("b2b_dv_n", dv_q.size(), 2);
    chk("b2b_dv0_at", q_at(dv_q, 0), 321);
    chk("b2b_dv1_at", q_at(dv_q, 1), 674);
    chk("b2b_dv_gap", q_at(dv_q, 1) - q_at(dv_q, 0), 353);
    chk("b2b_cnt0_first", cnt0_first, 321);
    chk("b2b_cnt0_n", cnt0_n, 4);
    chk("b2b_par_chk_n", par_chk_n, 32);
    chk("b2b_deser_n", deser_q.size(), 16);
    chk("b2b_err_n", fe_q.size() + pe_q.size(), 0);

    // Reset mid-DATA, P=8
    bus.PAR_EN = 1'b0;
    run_frame(8, 1'b0, 1'b0, 0, 20);
    chk("mid_pre_cnt_en", int'(bus.cnt_enable), 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_reset_outs", all_outs(), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    dv_seen = 0;
    en_seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.data_valid) dv_seen++;
      if (bus.cnt_enable) en_seen++;
    end
    chk("mid_reset_no_dv", dv_seen, 0);
    chk("mid_reset_idle", en_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
